// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared constants and FSM state codes for the boot-stream instruction loader
package inst_loader_pkg;

    // Length header and instruction words are both 4 bytes, little-endian.
    localparam int LEN_BYTES   = 4;
    localparam int INSTR_WIDTH = 32;
    localparam int BYTE_CNT_W  = $clog2(LEN_BYTES);

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_LEN   = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_CHK   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte-stream input and instruction-memory write bus of the loader
//
// Signals:
//   in_byte / in_byte_valid / out_byte_ready : boot byte stream, consumed when valid & ready
//   out_IM_wr_en / out_IM_addr / out_IM_wr_data : one-cycle instruction-memory write
//   out_done_load_inst / out_load_error          : sticky completion / abort status
// Modports: slave = loader side, master = stream source / memory side.
interface inst_loader_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_byte_valid;
    logic [7:0]            in_byte;
    logic                  out_byte_ready;
    logic                  out_IM_wr_en;
    logic [DATA_WIDTH-1:0] out_IM_addr;
    logic [31:0]           out_IM_wr_data;
    logic                  out_done_load_inst;
    logic                  out_load_error;

    modport slave (
        input  in_byte_valid, in_byte,
        output out_byte_ready, out_IM_wr_en, out_IM_addr, out_IM_wr_data,
        output out_done_load_inst, out_load_error
    );

    modport master (
        output in_byte_valid, in_byte,
        input  out_byte_ready, out_IM_wr_en, out_IM_addr, out_IM_wr_data,
        input  out_done_load_inst, out_load_error
    );
endinterface

// File: rtl/inst_loader_asm.sv
// rtl/inst_loader_asm.sv - 4-byte little-endian word assembler with byte counter and full flag
//
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_accept        : a byte is consumed this cycle
//   i_byte          : the byte being consumed
//   o_word          : last assembled word (registered)
//   o_word_next     : word as it will look after this cycle's byte is merged
//   o_complete      : this cycle's accepted byte completes a word
//   o_full          : o_word holds a complete word not yet followed by a new byte
module inst_loader_asm
    import inst_loader_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_accept,
    input  logic [7:0]             i_byte,
    output logic [INSTR_WIDTH-1:0] o_word,
    output logic [INSTR_WIDTH-1:0] o_word_next,
    output logic                   o_complete,
    output logic                   o_full
);
    logic [BYTE_CNT_W-1:0]  r_cnt;
    logic [INSTR_WIDTH-1:0] r_word;
    logic                   r_full;

    // Byte lane chosen by the counter: byte 0 lands in bits [7:0].
    always_comb begin
        o_word_next = r_word;
        o_word_next[8*r_cnt +: 8] = i_byte;
    end

    assign o_complete = i_accept && (r_cnt == BYTE_CNT_W'(LEN_BYTES - 1));
    assign o_word     = r_word;
    assign o_full     = r_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_full <= 1'b0;
        end else if (i_accept) begin
            r_cnt  <= r_cnt + 1'b1;
            r_word <= o_word_next;
            r_full <= o_complete;
        end
    end
endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot-stream loader: length header, instruction words, IM writes
//
// Ports:
//   in_Clk : clock
//   Rst_N  : asynchronous active-low reset
//   bus    : inst_loader_if.slave (byte stream in, IM write and status out)
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MAX_WORDS  = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic          in_Clk,
    input  logic          Rst_N,
    inst_loader_if.slave  bus
);
    localparam int IDX_W = $clog2(MAX_WORDS + 1);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_END = ST_CHK;
`else
    localparam logic [2:0] ST_END = ST_DONE;
`endif

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_live;
    logic [IDX_W-1:0]       r_index;
    logic [IDX_W-1:0]       r_count;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_asm_accept;
    logic                   w_complete;
    logic                   w_full;
    logic                   w_len_ok;
    logic [INSTR_WIDTH-1:0] w_word;
    logic [INSTR_WIDTH-1:0] w_word_next;

    // r_live keeps ready low until the first edge after reset release.
    assign w_ready      = r_live && (r_state == ST_LEN || r_state == ST_DATA || r_state == ST_CHK);
    assign w_accept     = w_ready && bus.in_byte_valid;
    assign w_asm_accept = w_accept && (r_state == ST_LEN || r_state == ST_DATA);
    assign w_len_ok     = (w_word_next <= INSTR_WIDTH'(MAX_WORDS));

    inst_loader_asm u_asm (
        .i_clk       (in_Clk),
        .i_rst_n     (Rst_N),
        .i_accept    (w_asm_accept),
        .i_byte      (bus.in_byte),
        .o_word      (w_word),
        .o_word_next (w_word_next),
        .o_complete  (w_complete),
        .o_full      (w_full)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_chk;

    always_ff @(posedge in_Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_chk <= 8'h00;
        end else if (w_asm_accept) begin
            r_chk <= r_chk ^ bus.in_byte;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LEN: begin
                if (w_asm_accept && w_complete) begin
                    if (w_word_next == '0)  w_state_nxt = ST_END;
                    else if (!w_len_ok)     w_state_nxt = ST_ERR;
                    else                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_asm_accept && w_complete) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_index + 1'b1 == r_count) w_state_nxt = ST_END;
                else                           w_state_nxt = ST_DATA;
            end
            ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_accept) w_state_nxt = (bus.in_byte == r_chk) ? ST_DONE : ST_ERR;
`else
                w_state_nxt = ST_ERR;
`endif
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge in_Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_state <= ST_LEN;
            r_live  <= 1'b0;
            r_index <= '0;
            r_count <= '0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_state_nxt;
            if (r_state == ST_LEN && w_asm_accept && w_complete && w_len_ok)
                r_count <= w_word_next[IDX_W-1:0];
            if (r_state == ST_WRITE)
                r_index <= r_index + 1'b1;
        end
    end

    assign bus.out_byte_ready     = w_ready;
    assign bus.out_IM_wr_en       = (r_state == ST_WRITE) && w_full;
    assign bus.out_IM_addr        = BASE_ADDR + (DATA_WIDTH'(r_index) << 2);
    assign bus.out_IM_wr_data     = w_word;
    assign bus.out_done_load_inst = (r_state == ST_DONE);
    assign bus.out_load_error     = (r_state == ST_ERR);
endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of out_IM_addr.
REQ-002 Parameter MAX_WORDS, default 1024: largest accepted instruction count.
REQ-003 Parameter BASE_ADDR, default 0: byte address of the first written instruction.
REQ-004 in_Clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Rst_N  input  1  asynchronous, active-low reset.
REQ-006 in_byte  input  8  incoming boot-stream byte.
REQ-007 in_byte_valid  input  1  in_byte holds a valid byte.
REQ-008 out_byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 out_IM_wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 out_IM_addr  output  DATA_WIDTH  instruction-memory byte address.
REQ-011 out_IM_wr_data  output  32  instruction word to write.
REQ-012 out_done_load_inst  output  1  load completed successfully; core reset may be released.
REQ-013 out_load_error  output  1  load aborted; sticky until reset.

Function
REQ-014 A byte SHALL be consumed only on a cycle where in_byte_valid and out_byte_ready are both high.
REQ-015 States SHALL be LEN, DATA, WRITE, CHK, DONE, ERR; reset state LEN.
- LEN: accept 4 bytes, little-endian, into 32-bit word count N.
- LEN exit: N=0 -> DONE (or CHK if LOADER_CHECKSUM_EN); N>MAX_WORDS -> ERR; else -> DATA.
- DATA: accept 4 bytes little-endian into one instruction word; 4th byte -> WRITE.
- WRITE: exactly one cycle; out_IM_wr_en=1, out_IM_addr=BASE_ADDR+4*index, out_IM_wr_data=word; index increments.
- WRITE exit: index reaches N -> DONE (or CHK); else -> DATA.
- DONE, ERR: terminal until reset.
REQ-016 out_byte_ready SHALL be 1 in LEN, DATA, CHK and 0 in WRITE, DONE, ERR.
REQ-017 Latency: the WRITE strobe SHALL appear the cycle after the 4th byte of a word is accepted.
REQ-018 Stalls: in_byte_valid low for any number of cycles mid-word SHALL preserve partial byte state.
REQ-019 Index and address arithmetic: index is clog2(MAX_WORDS+1) bits; address computed at DATA_WIDTH, no wrap for in-range N.
REQ-020 out_done_load_inst SHALL rise on DONE entry and stay high; out_load_error likewise on ERR entry.
REQ-021 Bytes presented in DONE or ERR SHALL be ignored (not consumed).

Reset
REQ-022 Rst_N low SHALL asynchronously force state LEN and clear byte counter, word assembler, N, index, checksum.
REQ-023 Output reset values: out_byte_ready 0, out_IM_wr_en 0, out_IM_addr BASE_ADDR, out_IM_wr_data 0, out_done_load_inst 0, out_load_error 0.
REQ-024 out_byte_ready SHALL go high the first clock edge after Rst_N deasserts.
REQ-025 Reset mid-load SHALL abandon the transfer; the next stream restarts at LEN with index 0.

Configuration
REQ-026 Macro LOADER_CHECKSUM_EN: when defined, a running XOR of all length and data bytes is kept, and one trailing byte is accepted in CHK; match -> DONE, mismatch -> ERR.
REQ-027 Without LOADER_CHECKSUM_EN: no CHK state, no trailing byte, out_load_error set only by N>MAX_WORDS.

Structure
REQ-028 Shared package SHALL hold the state enumeration, the 4-byte length-header width constant and the instruction width (32).
REQ-029 One sub-module inst_loader_asm (4-byte little-endian word assembler with byte counter and full flag) is natural; the FSM lives in inst_loader.

Verification
REQ-030 Stream 02 00 00 00, 13 00 00 00, 93 00 10 00 -> writes 0x00000013 at BASE_ADDR, 0x00100093 at BASE_ADDR+4; done=1.
REQ-031 Header N=0 -> no wr_en pulse; done=1 (after checksum byte 0x00 when enabled).
REQ-032 Header N=MAX_WORDS+1 -> no writes, error=1, ready=0, done=0.
REQ-033 Valid deasserted 5 cycles between bytes 2 and 3 of a word -> same written word, write one cycle after 4th byte.
REQ-034 Rst_N pulsed low after 2 of 3 words -> outputs at reset values; full restream writes index 0 again.
REQ-035 With LOADER_CHECKSUM_EN, corrupt trailing byte -> error=1, done=0; correct byte -> done=1.
